dmem_arbiter: RTL and testbench

Shared data-memory arbiter sitting directly downstream of the memory stages of both processing elements (PE1, PE2). It accepts one load/store request per PE per cycle and serialises them onto a single-port synchronous data memory with round-robin priority. It stalls the losing PE and returns read data to the PE that issued the load. This replaces the per-PE private data memories.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 40 ++++
 rtl/rr_arb2.sv | 39 +++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dual-PE data-memory arbiter.
//   - default data / word-address widths
//   - round-robin priority state encoding
//   - PE identifiers used to tag outstanding loads
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_MEM_AW = 10;

  typedef enum logic {
    PRI1 = 1'b0,
    PRI2 = 1'b1
  } pri_e;

  localparam logic PE1 = 1'b0;
  localparam logic PE2 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both PE request ports and the single-port memory
// side of the arbiter.
//   slave  : arbiter view (takes requests + mem read data, drives the rest)
//   master : environment view (PEs and memory)
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int MEM_AW = DMEM_MEM_AW
);

  logic              req1_i,    req2_i;
  logic              we1_i,     we2_i;
  logic [31:0]       addr1_i,   addr2_i;
  logic [DATA_W-1:0] wdata1_i,  wdata2_i;
  logic              gnt1_o,    gnt2_o;
  logic              stall1_o,  stall2_o;
  logic              rvalid1_o, rvalid2_o;
  logic [DATA_W-1:0] rdata1_o,  rdata2_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  req1_i, req2_i, we1_i, we2_i, addr1_i, addr2_i,
           wdata1_i, wdata2_i, mem_rdata_i,
    output gnt1_o, gnt2_o, stall1_o, stall2_o, rvalid1_o, rvalid2_o,
           rdata1_o, rdata2_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req1_i, req2_i, we1_i, we2_i, addr1_i, addr2_i,
           wdata1_i, wdata2_i, mem_rdata_i,
    input  gnt1_o, gnt2_o, stall1_o, stall2_o, rvalid1_o, rvalid2_o,
           rdata1_o, rdata2_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant with its priority register.
//   clk, rst_n     : clock, async active-low reset
//   i_req1, i_req2 : requests
//   o_gnt1, o_gnt2 : combinational one-hot (or zero) grant
//
// state | meaning
// PRI1  | PE1 wins a conflict
// PRI2  | PE2 wins a conflict
module rr_arb2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req1,
  input  logic i_req2,
  output logic o_gnt1,
  output logic o_gnt2
);

  pri_e r_state;
  pri_e w_state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PRI1;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    o_gnt1      = 1'b0;
    o_gnt2      = 1'b0;
    w_state_nxt = r_state;
    if (i_req1 && (!i_req2 || r_state == PRI1)) o_gnt1 = 1'b1;
    else if (i_req2)                            o_gnt2 = 1'b1;
    // Winner hands priority to the other PE; idle cycles keep it.
    if (o_gnt1)      w_state_nxt = PRI2;
    else if (o_gnt2) w_state_nxt = PRI1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises PE1/PE2 load/store requests onto one single-port
// synchronous data memory with round-robin priority and routes load data back
// to the issuing PE one cycle after its grant.
//   clk, rst : clock, async active-low reset
//   bus      : dmem_arbiter_if.slave (PE request/response + memory port)
//   grant1_cnt_o, grant2_cnt_o, conflict_cnt_o : 32-bit event counters,
//              present only when DMEM_ARB_STATS_EN is defined
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int MEM_AW = DMEM_MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       grant1_cnt_o,
  output logic [31:0]       grant2_cnt_o,
  output logic [31:0]       conflict_cnt_o
`endif
);

  logic              w_req1, w_req2;
  logic              w_gnt1, w_gnt2;
  logic              w_mem_en, w_mem_we;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_rvalid1, w_rvalid2;
  logic              w_unused_addr;

  logic              r_rd_pend;
  logic              r_rd_owner;
  logic [DATA_W-1:0] r_rdata1, r_rdata2;

  // Requests are masked during reset so every output sits at its reset value.
  assign w_req1 = bus.req1_i & rst;
  assign w_req2 = bus.req2_i & rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst),
    .i_req1 (w_req1),
    .i_req2 (w_req2),
    .o_gnt1 (w_gnt1),
    .o_gnt2 (w_gnt2)
  );

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_gnt1) begin
      w_mem_we    = bus.we1_i;
      w_mem_addr  = bus.addr1_i[MEM_AW+1:2];
      w_mem_wdata = bus.wdata1_i;
    end else if (w_gnt2) begin
      w_mem_we    = bus.we2_i;
      w_mem_addr  = bus.addr2_i[MEM_AW+1:2];
      w_mem_wdata = bus.wdata2_i;
    end
  end

  assign w_mem_en = w_gnt1 | w_gnt2;

  // Byte-lane and above-depth address bits are ignored, so addresses alias.
  assign w_unused_addr = ^{bus.addr1_i[31:MEM_AW+2], bus.addr1_i[1:0],
                           bus.addr2_i[31:MEM_AW+2], bus.addr2_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= PE1;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
    end else begin
      r_rd_pend  <= w_mem_en & ~w_mem_we;
      r_rd_owner <= w_gnt2 ? PE2 : PE1;
      if (w_rvalid1) r_rdata1 <= bus.mem_rdata_i;
      if (w_rvalid2) r_rdata2 <= bus.mem_rdata_i;
    end
  end

  assign w_rvalid1 = r_rd_pend & (r_rd_owner == PE1);
  assign w_rvalid2 = r_rd_pend & (r_rd_owner == PE2);

  // The owner sees memory data directly in its rvalid cycle; the other PE
  // keeps showing whatever it last received.
  assign bus.rdata1_o    = w_rvalid1 ? bus.mem_rdata_i : r_rdata1;
  assign bus.rdata2_o    = w_rvalid2 ? bus.mem_rdata_i : r_rdata2;
  assign bus.rvalid1_o   = w_rvalid1;
  assign bus.rvalid2_o   = w_rvalid2;
  assign bus.gnt1_o      = w_gnt1;
  assign bus.gnt2_o      = w_gnt2;
  assign bus.stall1_o    = w_req1 & ~w_gnt1;
  assign bus.stall2_o    = w_req2 & ~w_gnt2;
  assign bus.mem_en_o    = w_mem_en;
  assign bus.mem_we_o    = w_mem_we;
  assign bus.mem_addr_o  = w_mem_addr;
  assign bus.mem_wdata_o = w_mem_wdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_grant1_cnt, r_grant2_cnt, r_conflict_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant1_cnt   <= '0;
      r_grant2_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt1)           r_grant1_cnt   <= r_grant1_cnt + 32'd1;
      if (w_gnt2)           r_grant2_cnt   <= r_grant2_cnt + 32'd1;
      if (w_req1 && w_req2) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign grant1_cnt_o   = r_grant1_cnt;
  assign grant2_cnt_o   = r_grant2_cnt;
  assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter with a
// behavioural single-port synchronous memory.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dmem_arbiter_if #(.DATA_W(32), .MEM_AW(10)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grant1_cnt, grant2_cnt, conflict_cnt;
`endif

  dmem_arbiter #(.DATA_W(32), .MEM_AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant1_cnt_o   (grant1_cnt),
    .grant2_cnt_o   (grant2_cnt),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i     <= mem[bus.mem_addr_o];
    end
  end

  typedef struct packed {
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        r2;
    logic        w2;
    logic [31:0] a2;
    logic [31:0] d2;
    logic        g1;
    logic        g2;
    logic        s1;
    logic        s2;
    logic        v1;
    logic        v2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        men;
    logic        mwe;
    logic [9:0]  maddr;
    logic [31:0] mwd;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [0:NV-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic r2, input logic w2,
                       input logic [31:0] a2, input logic [31:0] d2);
    bus.req1_i = r1; bus.we1_i = w1; bus.addr1_i = a1; bus.wdata1_i = d1;
    bus.req2_i = r2; bus.we2_i = w2; bus.addr2_i = a2; bus.wdata2_i = d2;
  endtask

  task automatic chk_outs(input string tag, input vec_t e);
    chk({tag, ".gnt1"},      {31'd0, bus.gnt1_o},    {31'd0, e.g1});
    chk({tag, ".gnt2"},      {31'd0, bus.gnt2_o},    {31'd0, e.g2});
    chk({tag, ".stall1"},    {31'd0, bus.stall1_o},  {31'd0, e.s1});
    chk({tag, ".stall2"},    {31'd0, bus.stall2_o},  {31'd0, e.s2});
    chk({tag, ".rvalid1"},   {31'd0, bus.rvalid1_o}, {31'd0, e.v1});
    chk({tag, ".rvalid2"},   {31'd0, bus.rvalid2_o}, {31'd0, e.v2});
    chk({tag, ".rdata1"},    bus.rdata1_o,           e.rd1);
    chk({tag, ".rdata2"},    bus.rdata2_o,           e.rd2);
    chk({tag, ".mem_en"},    {31'd0, bus.mem_en_o},  {31'd0, e.men});
    chk({tag, ".mem_we"},    {31'd0, bus.mem_we_o},  {31'd0, e.mwe});
    chk({tag, ".mem_addr"},  {22'd0, bus.mem_addr_o}, {22'd0, e.maddr});
    chk({tag, ".mem_wdata"}, bus.mem_wdata_o,        e.mwd);
  endtask

  vec_t ev;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // r1 w1 a1 d1 | r2 w2 a2 d2 | g1 g2 s1 s2 v1 v2 | rd1 rd2 | men mwe maddr mwd
    vecs[0]  = '{'1,'1,32'h4,32'h11111111, '0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0, '1,'1,10'h1,32'h11111111};
    vecs[1]  = '{'0,'0,'0,'0, '1,'1,32'h8,32'h22222222, '0,'1,'0,'0,'0,'0, '0,'0, '1,'1,10'h2,32'h22222222};
    vecs[2]  = '{'1,'0,32'h4,'0, '1,'0,32'h8,'0, '1,'0,'0,'1,'0,'0, '0,'0, '1,'0,10'h1,'0};
    vecs[3]  = '{'1,'0,32'h4,'0, '1,'0,32'h8,'0, '0,'1,'1,'0,'1,'0, 32'h11111111,'0, '1,'0,10'h2,'0};
    vecs[4]  = '{'1,'0,32'h4,'0, '1,'0,32'h8,'0, '1,'0,'0,'1,'0,'1, 32'h11111111,32'h22222222, '1,'0,10'h1,'0};
    vecs[5]  = '{'1,'0,32'h4,'0, '1,'0,32'h8,'0, '0,'1,'1,'0,'1,'0, 32'h11111111,32'h22222222, '1,'0,10'h2,'0};
    vecs[6]  = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,'0,'0,'1, 32'h11111111,32'h22222222, '0,'0,'0,'0};
    vecs[7]  = '{'1,'1,32'h10,32'hDEADBEEF, '0,'0,'0,'0, '1,'0,'0,'0,'0,'0, 32'h11111111,32'h22222222, '1,'1,10'h4,32'hDEADBEEF};
    vecs[8]  = '{'1,'0,32'h10,'0, '0,'0,'0,'0, '1,'0,'0,'0,'0,'0, 32'h11111111,32'h22222222, '1,'0,10'h4,'0};
    vecs[9]  = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,'0,'1,'0, 32'hDEADBEEF,32'h22222222, '0,'0,'0,'0};
    vecs[10] = '{'0,'0,'0,'0, '1,'1,32'h30,32'h5, '0,'1,'0,'0,'0,'0, 32'hDEADBEEF,32'h22222222, '1,'1,10'hC,32'h5};
    vecs[11] = '{'1,'1,32'h20,32'h1, '1,'1,32'h20,32'h2, '1,'0,'0,'1,'0,'0, 32'hDEADBEEF,32'h22222222, '1,'1,10'h8,32'h1};
    vecs[12] = '{'0,'0,'0,'0, '1,'1,32'h20,32'h2, '0,'1,'0,'0,'0,'0, 32'hDEADBEEF,32'h22222222, '1,'1,10'h8,32'h2};
    vecs[13] = '{'1,'0,32'h20,'0, '0,'0,'0,'0, '1,'0,'0,'0,'0,'0, 32'hDEADBEEF,32'h22222222, '1,'0,10'h8,'0};
    vecs[14] = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,'0,'1,'0, 32'h2,32'h22222222, '0,'0,'0,'0};
    vecs[15] = '{'0,'0,'0,'0, '1,'1,32'h1000,32'hA5, '0,'1,'0,'0,'0,'0, 32'h2,32'h22222222, '1,'1,10'h0,32'hA5};
    vecs[16] = '{'0,'0,'0,'0, '1,'0,32'h0,'0, '0,'1,'0,'0,'0,'0, 32'h2,32'h22222222, '1,'0,10'h0,'0};
    vecs[17] = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,'0,'0,'1, 32'h2,32'hA5, '0,'0,'0,'0};
    vecs[18] = '{'1,'0,32'h30,'0, '0,'0,'0,'0, '1,'0,'0,'0,'0,'0, 32'h2,32'hA5, '1,'0,10'hC,'0};
    vecs[19] = '{'0,'0,'0,'0, '1,'1,32'h30,32'h77, '0,'1,'0,'0,'1,'0, 32'h5,32'hA5, '1,'1,10'hC,32'h77};
    vecs[20] = '{'1,'0,32'h30,'0, '0,'0,'0,'0, '1,'0,'0,'0,'0,'0, 32'h5,32'hA5, '1,'0,10'hC,'0};
    vecs[21] = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,'0,'1,'0, 32'h77,32'hA5, '0,'0,'0,'0};

    // Reset values.
    rst = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    ev = '0;
    chk_outs("reset", ev);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1,
            vecs[i].r2, vecs[i].w2, vecs[i].a2, vecs[i].d2);
      @(negedge clk);
      chk_outs($sformatf("v%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset mid-read: PE1 load granted while priority is PRI2, then reset
    // lands in the rvalid cycle with both PEs still requesting.
    drive('1, '0, 32'h4, '0, '0, '0, '0, '0);
    @(negedge clk);
    chk("rstseq.load_gnt1", {31'd0, bus.gnt1_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive('1, '0, 32'h4, '0, '1, '0, 32'h8, '0);
    @(negedge clk);
    ev = '0;
    chk_outs("rstseq.in_reset", ev);
    @(posedge clk);
    #1;
    chk_outs("rstseq.in_reset2", ev);
    rst = 1'b1;
    @(negedge clk);
    ev = '0;
    ev.g1 = 1'b1; ev.s2 = 1'b1; ev.men = 1'b1; ev.maddr = 10'h1;
    chk_outs("rstseq.after", ev);
    @(posedge clk);
    #1;
    drive('0, '0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    chk("rstseq.post_rvalid1", {31'd0, bus.rvalid1_o}, 32'd1);
    chk("rstseq.post_rdata1", bus.rdata1_o, 32'h11111111);
    chk("rstseq.post_rvalid2", {31'd0, bus.rvalid2_o}, 32'd0);

`ifdef DMEM_ARB_STATS_EN
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("stats.rst_g1", grant1_cnt, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive('1, '0, 32'h4, '0, '1, '0, 32'h8, '0);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      drive('1, '0, 32'h4, '0, '0, '0, '0, '0);
      @(posedge clk);
      #1;
    end
    drive('0, '0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    chk("stats.grant1", grant1_cnt, 32'd4);
    chk("stats.grant2", grant2_cnt, 32'd1);
    chk("stats.conflict", conflict_cnt, 32'd3);
`endif

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
